// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I memory stage. Runs req/gnt/rvalid data-bus
// transactions for loads/stores and forwards ALU results to writeback.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN: trap misaligned half/word.
// Ports: i_clk, i_rst_n, i_valid/o_ready (upstream), i_control_signal,
//   i_address, i_store_data, o_dbus_* / i_dbus_* (bus), o_wb_* (writeback),
//   o_mem_err (misalign / illegal funct3 pulse).

package rapid_pkg;
   parameter int XLEN = 32;

   typedef struct packed {
      logic        mem;
      logic        iop;
      logic [2:0]  fcs_opcode;
      logic [4:0]  rd;
      logic [31:0] debug_instruction;
   } control_mem_s;
endpackage

module mem_access_unit
   import rapid_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  control_mem_s      i_control_signal,
   input  logic [XLEN-1:0]   i_address,
   input  logic [XLEN-1:0]   i_store_data,
   output logic              o_dbus_req,
   output logic              o_dbus_we,
   output logic [ADDR_W-1:0] o_dbus_addr,
   output logic [3:0]        o_dbus_be,
   output logic [XLEN-1:0]   o_dbus_wdata,
   input  logic              i_dbus_gnt,
   input  logic              i_dbus_rvalid,
   input  logic [XLEN-1:0]   i_dbus_rdata,
   output logic              o_wb_valid,
   output logic              o_wb_we,
   output logic [4:0]        o_wb_rd,
   output logic [XLEN-1:0]   o_wb_data,
   output logic              o_mem_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q;
   logic              iop_q;

   logic [2:0]  f3;
   logic [1:0]  off;
   logic        accept, illegal, misalign, mem_go, mem_err_d;
   logic [31:0] unused_dbg;

   logic [7:0]      lb;
   logic [15:0]     lh;
   logic [XLEN-1:0] ld_data;

   assign f3         = i_control_signal.fcs_opcode;
   assign off        = i_address[1:0];
   assign unused_dbg = i_control_signal.debug_instruction;

   assign accept  = i_valid && (state_q == IDLE);
   assign illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misalign = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign mem_go    = accept && i_control_signal.mem && !illegal && !misalign;
   assign mem_err_d = accept && i_control_signal.mem && (illegal || misalign);

   // Lane steering: funct3[1:0] is the access width for loads and stores.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = i_store_data;
      case (f3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << off;
            wdata_d = {4{i_store_data[7:0]}};
         end
         2'b01: begin
            be_d    = off[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{i_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   lb = i_dbus_rdata[7:0];
         2'b01:   lb = i_dbus_rdata[15:8];
         2'b10:   lb = i_dbus_rdata[23:16];
         default: lb = i_dbus_rdata[31:24];
      endcase
      lh = addr_q[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{lb[7]}}, lb};
         3'b100:  ld_data = {24'b0, lb};
         3'b001:  ld_data = {{16{lh[15]}}, lh};
         3'b101:  ld_data = {16'b0, lh};
         default: ld_data = i_dbus_rdata;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_go) state_d = REQ;
         REQ:     if (i_dbus_gnt) state_d = iop_q ? IDLE : WAIT;
         WAIT:    if (i_dbus_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      o_ready    = (state_q == IDLE);
      o_dbus_req = (state_q == REQ);
   end

   assign o_dbus_we    = iop_q;
   assign o_dbus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign o_dbus_be    = be_q;
   assign o_dbus_wdata = wdata_q;

   // Transaction context and writeback pulse registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
         iop_q      <= 1'b0;
         o_wb_valid <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_rd    <= '0;
         o_wb_data  <= '0;
         o_mem_err  <= 1'b0;
      end else begin
         o_wb_valid <= 1'b0;
         o_mem_err  <= 1'b0;
         if (mem_go) begin
            addr_q  <= i_address[ADDR_W-1:0];
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3;
            rd_q    <= i_control_signal.rd;
            iop_q   <= i_control_signal.iop;
         end
         if (accept && !i_control_signal.mem) begin
            o_wb_valid <= 1'b1;
            o_wb_we    <= (i_control_signal.rd != 5'd0);
            o_wb_rd    <= i_control_signal.rd;
            o_wb_data  <= i_address;
         end
         if (mem_err_d) begin
            o_wb_valid <= 1'b1;
            o_wb_we    <= 1'b0;
            o_wb_rd    <= i_control_signal.rd;
            o_wb_data  <= '0;
            o_mem_err  <= 1'b1;
         end
         if ((state_q == REQ) && i_dbus_gnt && iop_q) begin
            o_wb_valid <= 1'b1;
            o_wb_we    <= 1'b0;
            o_wb_rd    <= rd_q;
            o_wb_data  <= '0;
         end
         if ((state_q == WAIT) && i_dbus_rvalid) begin
            o_wb_valid <= 1'b1;
            o_wb_we    <= (rd_q != 5'd0);
            o_wb_rd    <= rd_q;
            o_wb_data  <= ld_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized checks of mem_access_unit
// against a behavioural model of the memory-stage rules.

module tb_mem_access_unit;
   import rapid_pkg::*;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   control_mem_s ctrl;
   logic [31:0]  i_address = '0;
   logic [31:0]  i_store_data = '0;
   logic         o_dbus_req, o_dbus_we;
   logic [31:0]  o_dbus_addr;
   logic [3:0]   o_dbus_be;
   logic [31:0]  o_dbus_wdata;
   logic         i_dbus_gnt = 1'b0;
   logic         i_dbus_rvalid = 1'b0;
   logic [31:0]  i_dbus_rdata = '0;
   logic         o_wb_valid, o_wb_we;
   logic [4:0]   o_wb_rd;
   logic [31:0]  o_wb_data;
   logic         o_mem_err;

   int n_chk = 0;
   int n_fail = 0;

   mem_access_unit #(.ADDR_W(32)) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_control_signal(ctrl),
      .i_address       (i_address),
      .i_store_data    (i_store_data),
      .o_dbus_req      (o_dbus_req),
      .o_dbus_we       (o_dbus_we),
      .o_dbus_addr     (o_dbus_addr),
      .o_dbus_be       (o_dbus_be),
      .o_dbus_wdata    (o_dbus_wdata),
      .i_dbus_gnt      (i_dbus_gnt),
      .i_dbus_rvalid   (i_dbus_rvalid),
      .i_dbus_rdata    (i_dbus_rdata),
      .o_wb_valid      (o_wb_valid),
      .o_wb_we         (o_wb_we),
      .o_wb_rd         (o_wb_rd),
      .o_wb_data       (o_wb_data),
      .o_mem_err       (o_mem_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(string tag, logic obs, logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_err(logic [2:0] f3, logic [31:0] a);
      int w;
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
      w = int'(f3 % 4);
      if (TRAP && w == 1 && (a % 2) != 0) return 1'b1;
      if (TRAP && w == 2 && (a % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
      int o;
      o = int'(a % 4);
      case (f3 % 4)
         0: return 4'(1 << o);
         1: return 4'(3 << ((o / 2) * 2));
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
      case (f3 % 4)
         0: return (d & 32'hFF) * 32'h0101_0101;
         1: return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a,
                                          logic [31:0] w);
      logic [31:0] v;
      int o;
      o = int'(a % 4);
      case (f3)
         3'd0, 3'd4: begin
            v = (w >> (8 * o)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
         end
         3'd1, 3'd5: begin
            v = (w >> (16 * (o / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(bit mem, bit st, logic [2:0] f3, logic [4:0] rd,
                        logic [31:0] a, logic [31:0] d);
      ctrl.mem               = mem;
      ctrl.iop               = st;
      ctrl.fcs_opcode        = f3;
      ctrl.rd                = rd;
      ctrl.debug_instruction = $urandom;
      i_address              = a;
      i_store_data           = d;
   endtask

   task automatic do_alu(logic [4:0] rd, logic [31:0] a);
      chk1("alu_ready", o_ready, 1'b1);
      drive(1'b0, 1'b0, 3'($urandom_range(0, 7)), rd, a, $urandom);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk1("alu_wb_valid", o_wb_valid, 1'b1);
      chk1("alu_wb_we", o_wb_we, rd != 5'd0);
      chk32("alu_wb_rd", 32'(o_wb_rd), 32'(rd));
      chk32("alu_wb_data", o_wb_data, a);
      chk1("alu_no_req", o_dbus_req, 1'b0);
   endtask

   task automatic do_mem(bit st, logic [2:0] f3, logic [31:0] a,
                         logic [31:0] d, logic [31:0] rw, int gdly,
                         int rdly, logic [4:0] rd, logic [31:0] exp_data);
      chk1("mem_ready", o_ready, 1'b1);
      drive(1'b1, st, f3, rd, a, d);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      if (m_err(f3, a)) begin
         chk1("err_pulse", o_mem_err, 1'b1);
         chk1("err_wb_valid", o_wb_valid, 1'b1);
         chk1("err_wb_we", o_wb_we, 1'b0);
         chk1("err_no_req", o_dbus_req, 1'b0);
         chk1("err_ready", o_ready, 1'b1);
         tick();
         chk1("err_pulse_end", o_mem_err, 1'b0);
         chk1("err_no_req2", o_dbus_req, 1'b0);
         return;
      end
      chk1("mem_no_err", o_mem_err, 1'b0);
      chk1("mem_busy", o_ready, 1'b0);
      chk1("mem_no_wb", o_wb_valid, 1'b0);
      for (int k = 0; k <= gdly; k++) begin
         chk1("req_held", o_dbus_req, 1'b1);
         chk1("req_we", o_dbus_we, st);
         chk32("req_addr", o_dbus_addr, a & 32'hFFFF_FFFC);
         chk32("req_be", 32'(o_dbus_be), 32'(m_be(f3, a)));
         if (st) chk32("req_wdata", o_dbus_wdata, m_wdata(f3, d));
         if (k == gdly) i_dbus_gnt = 1'b1;
         tick();
         i_dbus_gnt = 1'b0;
      end
      chk1("gnt_req_drop", o_dbus_req, 1'b0);
      if (st) begin
         chk1("st_wb_valid", o_wb_valid, 1'b1);
         chk1("st_wb_we", o_wb_we, 1'b0);
         chk1("st_ready", o_ready, 1'b1);
         return;
      end
      for (int k = 0; k < rdly; k++) begin
         chk1("wait_busy", o_ready, 1'b0);
         chk1("wait_no_wb", o_wb_valid, 1'b0);
         tick();
      end
      chk1("wait_busy2", o_ready, 1'b0);
      i_dbus_rvalid = 1'b1;
      i_dbus_rdata  = rw;
      tick();
      i_dbus_rvalid = 1'b0;
      i_dbus_rdata  = $urandom;
      chk1("ld_wb_valid", o_wb_valid, 1'b1);
      chk1("ld_wb_we", o_wb_we, rd != 5'd0);
      chk32("ld_wb_rd", 32'(o_wb_rd), 32'(rd));
      chk32("ld_wb_data", o_wb_data, exp_data);
      chk1("ld_ready", o_ready, 1'b1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [4:0]  rds [4];
      logic [31:0] dat [4];
      logic [31:0] a, d, w;
      logic [2:0]  f3;
      logic [4:0]  rd;
      int          kind;

      drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
      tick();
      tick();
      chk1("rst_ready", o_ready, 1'b1);
      chk1("rst_req", o_dbus_req, 1'b0);
      chk1("rst_wb_valid", o_wb_valid, 1'b0);
      chk1("rst_err", o_mem_err, 1'b0);
      chk32("rst_addr", o_dbus_addr, 32'd0);
      i_rst_n = 1'b1;
      tick();

      // ALU passthrough, back-to-back
      rds[0] = 5'd5;  dat[0] = 32'h0000_1234;
      rds[1] = 5'd0;  dat[1] = $urandom;
      rds[2] = 5'd17; dat[2] = $urandom;
      rds[3] = 5'd31; dat[3] = $urandom;
      i_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 3'd2, rds[i], dat[i], 32'd0);
         tick();
         chk1("b2b_wb_valid", o_wb_valid, 1'b1);
         chk1("b2b_wb_we", o_wb_we, rds[i] != 5'd0);
         chk32("b2b_wb_rd", 32'(o_wb_rd), 32'(rds[i]));
         chk32("b2b_wb_data", o_wb_data, dat[i]);
         chk1("b2b_ready", o_ready, 1'b1);
      end
      i_valid = 1'b0;
      tick();
      chk1("b2b_idle", o_wb_valid, 1'b0);

      // Directed memory cases
      do_mem(1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'd0, 3, 0, 5'd9, 32'd0);
      do_mem(1'b0, 3'b000, 32'h2002, 32'd0, 32'h12F4_5678, 1, 1, 5'd3,
             32'hFFFF_FFF4);
      do_mem(1'b0, 3'b100, 32'h2002, 32'd0, 32'h12F4_5678, 0, 0, 5'd4,
             32'h0000_00F4);
      do_mem(1'b0, 3'b101, 32'h2002, 32'd0, 32'h12F4_5678, 2, 1, 5'd6,
             32'h0000_12F4);
      do_mem(1'b0, 3'b010, 32'h3000, 32'd0, 32'hDEAD_BEEF, 0, 2, 5'd7,
             32'hDEAD_BEEF);
      do_mem(1'b0, 3'b010, 32'h4002, 32'd0, 32'hCAFE_F00D, 0, 0, 5'd8,
             32'hCAFE_F00D);
      do_mem(1'b0, 3'b011, 32'h5000, 32'd0, 32'd0, 0, 0, 5'd10, 32'd0);
      do_mem(1'b0, 3'b000, 32'h6001, 32'd0, 32'h0000_8000, 0, 0, 5'd0,
             32'hFFFF_FF80);

      // Randomized mix against the model
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         a    = $urandom;
         d    = $urandom;
         w    = $urandom;
         rd   = 5'($urandom_range(0, 31));
         if (kind == 0) begin
            do_alu(rd, a);
         end else if (kind == 1) begin
            f3 = 3'($urandom_range(0, 7));
            do_mem(1'b0, f3, a, d, w, $urandom_range(0, 3),
                   $urandom_range(0, 3), rd, m_load(f3, a, w));
         end else begin
            case ($urandom_range(0, 5))
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd3;
               4: f3 = 3'd6;
               default: f3 = 3'd7;
            endcase
            do_mem(1'b1, f3, a, d, w, $urandom_range(0, 3), 0, rd, 32'd0);
         end
      end

      // Reset while requesting
      drive(1'b1, 1'b0, 3'b010, 5'd1, 32'h7000, 32'd0);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk1("rreq_req", o_dbus_req, 1'b1);
      i_rst_n = 1'b0;
      #1;
      chk1("rreq_req_drop", o_dbus_req, 1'b0);
      chk1("rreq_ready", o_ready, 1'b1);
      tick();
      i_rst_n = 1'b1;
      tick();

      // Reset while waiting for read data, then stray bus events
      drive(1'b1, 1'b0, 3'b010, 5'd2, 32'h8000, 32'd0);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      i_dbus_gnt = 1'b1;
      tick();
      i_dbus_gnt = 1'b0;
      chk1("rwait_busy", o_ready, 1'b0);
      i_rst_n = 1'b0;
      #1;
      chk1("rwait_ready", o_ready, 1'b1);
      chk1("rwait_req", o_dbus_req, 1'b0);
      tick();
      i_rst_n = 1'b1;
      tick();
      i_dbus_rvalid = 1'b1;
      i_dbus_gnt    = 1'b1;
      tick();
      i_dbus_rvalid = 1'b0;
      i_dbus_gnt    = 1'b0;
      chk1("stray_no_wb", o_wb_valid, 1'b0);
      chk1("stray_no_req", o_dbus_req, 1'b0);
      chk1("stray_ready", o_ready, 1'b1);
      tick();
      chk1("stray_no_wb2", o_wb_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
